// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite write slave.
//   axi_resp_t          : 2-bit AXI response code
//   AXI_RESP_OKAY/SLVERR: response encodings used on the B channel
//   axi_lite_wr_state_t : write-path FSM states
package axi_lite_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    HAVE_AW,
    HAVE_W,
    WRITE,
    RESP
  } axi_lite_wr_state_t;

endpackage

// File: rtl/axi_lite_write_slave_if.sv
// AXI4-Lite write channels (AW, W, B) bundled for the write slave.
//   master modport : drives AW/W payload and valids, drives bready
//   slave modport  : drives awready/wready, bvalid/bresp
interface axi_lite_write_slave_if
  import axi_lite_pkg::*;
#(
  parameter int AXI_AWADDR_WIDTH = 8,
  parameter int AXI_DATA_WIDTH   = 32
);

  logic                          awvalid;
  logic                          awready;
  logic [AXI_AWADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                    awprot;
  logic                          wvalid;
  logic                          wready;
  logic [AXI_DATA_WIDTH-1:0]     wdata;
  logic [AXI_DATA_WIDTH/8-1:0]   wstrb;
  logic                          bvalid;
  logic                          bready;
  axi_resp_t                     bresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output awready, wready, bvalid, bresp
  );

endinterface

// File: rtl/axi_lite_write_slave.sv
// AXI4-Lite write slave: accepts one AW + one W (either order or together),
// turns the pair into a single register write request, then answers on B.
// One transaction in flight at a time.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   bus (slave)    : AW / W / B channels
//   reg_wvalid/reg_wready : register write handshake towards the register file
//   reg_windex     : word index (awaddr with the byte offset dropped)
//   reg_wdata/reg_wstrb   : write data and byte strobes
// Indices at or above REG_COUNT are answered with SLVERR and never reach the
// register file.
module axi_lite_write_slave
  import axi_lite_pkg::*;
#(
  parameter int AXI_AWADDR_WIDTH = 8,
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int REG_COUNT        = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  axi_lite_write_slave_if.slave         bus,
  output logic                          reg_wvalid,
  input  logic                          reg_wready,
  output logic [AXI_AWADDR_WIDTH-3:0]   reg_windex,
  output logic [AXI_DATA_WIDTH-1:0]     reg_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   reg_wstrb
);

  localparam int IDX_W = AXI_AWADDR_WIDTH - 2;
  // One extra bit so REG_COUNT == 2^IDX_W is representable in the compare.
  localparam logic [IDX_W:0] REG_LIMIT = (IDX_W + 1)'(REG_COUNT);

  axi_lite_wr_state_t state, state_next;

  logic             awready;
  logic             wready;
  logic             aw_hs;
  logic             w_hs;
  logic             decide;
  logic             in_range;
  logic [IDX_W-1:0] decide_idx;
  logic [2:0]       prot_q;
  axi_resp_t        bresp_q;

  assign aw_hs = bus.awvalid && awready;
  assign w_hs  = bus.wvalid && wready;

  // The index that decides WRITE vs error comes straight from awaddr when the
  // AW handshake completes the pair, otherwise from the already captured index.
  always_comb begin
    decide_idx = aw_hs ? bus.awaddr[AXI_AWADDR_WIDTH-1:2] : reg_windex;
    in_range   = {1'b0, decide_idx} < REG_LIMIT;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; 'decide' marks the edge where the AW/W pair completes.
  always_comb begin
    state_next = state;
    decide     = 1'b0;
    case (state)
      IDLE: begin
        if (aw_hs && w_hs) decide     = 1'b1;
        else if (aw_hs)    state_next = HAVE_AW;
        else if (w_hs)     state_next = HAVE_W;
      end
      HAVE_AW: if (w_hs)        decide     = 1'b1;
      HAVE_W:  if (aw_hs)       decide     = 1'b1;
      WRITE:   if (reg_wready)  state_next = RESP;
      RESP:    if (bus.bready)  state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
    if (decide) state_next = in_range ? WRITE : RESP;
  end

  // Outputs; all handshake outputs are forced to idle values while reset is high.
  always_comb begin
    awready    = 1'b0;
    wready     = 1'b0;
    reg_wvalid = 1'b0;
    bus.bvalid = 1'b0;
    bus.bresp  = AXI_RESP_OKAY;
    if (!reset) begin
      awready    = (state == IDLE) || (state == HAVE_W);
      wready     = (state == IDLE) || (state == HAVE_AW);
      reg_wvalid = (state == WRITE);
      bus.bvalid = (state == RESP);
      bus.bresp  = bresp_q;
    end
  end

  assign bus.awready = awready;
  assign bus.wready  = wready;

  // Capture registers for the request payload and the pending response.
  always_ff @(posedge clock) begin
    if (reset) begin
      reg_windex <= '0;
      reg_wdata  <= '0;
      reg_wstrb  <= '0;
      prot_q     <= '0;
      bresp_q    <= AXI_RESP_OKAY;
    end else begin
      if (aw_hs) begin
        reg_windex <= bus.awaddr[AXI_AWADDR_WIDTH-1:2];
        prot_q     <= bus.awprot;
      end
      if (w_hs) begin
        reg_wdata <= bus.wdata;
        reg_wstrb <= bus.wstrb;
      end
      if (decide) bresp_q <= in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    end
  end

  // Byte offset and protection bits have no consumer in this block.
  logic unused_bits;
  assign unused_bits = ^{bus.awaddr[1:0], prot_q};

endmodule

// File: tb/tb_axi_lite_write_slave.sv
// Directed bench for axi_lite_write_slave: reset values, both arrival orders,
// decode error, backpressure, reset mid-transaction, zero strobes, and a short
// randomised back-to-back run checked against a scoreboard.
module tb_axi_lite_write_slave;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        reg_wvalid;
  logic        reg_wready = 1'b0;
  logic [5:0]  reg_windex;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;

  int tests_run = 0;
  int tests_failed = 0;

  typedef logic [41:0] wr_t;   // {index, data, strb}
  wr_t wr_q[$];
  wr_t exp_q[$];
  int  b_cnt = 0;
  int  slverr_cnt = 0;
  bit  mon_en = 1'b0;
  bit  rnd_en = 1'b0;

  axi_lite_write_slave_if #(.AXI_AWADDR_WIDTH(8), .AXI_DATA_WIDTH(32)) bus ();

  axi_lite_write_slave #(
    .AXI_AWADDR_WIDTH(8),
    .AXI_DATA_WIDTH(32),
    .REG_COUNT(16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .reg_wvalid (reg_wvalid),
    .reg_wready (reg_wready),
    .reg_windex (reg_windex),
    .reg_wdata  (reg_wdata),
    .reg_wstrb  (reg_wstrb)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_pair(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bus.awvalid = 1'b1; bus.awaddr = addr; bus.awprot = 3'b010;
    bus.wvalid  = 1'b1; bus.wdata  = data; bus.wstrb  = strb;
  endtask

  task automatic idle_bus();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  // Observe handshakes on the falling edge, ahead of the rising edge that completes them.
  initial begin
    logic       prev_rstall, prev_bstall;
    wr_t        prev_wr;
    logic [1:0] prev_bresp;
    prev_rstall = 1'b0; prev_bstall = 1'b0; prev_wr = '0; prev_bresp = '0;
    forever begin
      @(negedge clock);
      if (reg_wvalid && reg_wready) wr_q.push_back({reg_windex, reg_wdata, reg_wstrb});
      if (bus.bvalid && bus.bready) begin
        b_cnt++;
        if (bus.bresp == 2'b10) slverr_cnt++;
      end
      if (mon_en) begin
        if (reg_wvalid || bus.bvalid)
          check_val("busy_readies", {62'd0, bus.awready, bus.wready}, 64'd0);
        if (prev_rstall) begin
          check_val("rnd_wvalid_hold", {63'd0, reg_wvalid}, 64'd1);
          check_val("rnd_payload_hold", {22'd0, reg_windex, reg_wdata, reg_wstrb}, {22'd0, prev_wr});
        end
        if (prev_bstall) begin
          check_val("rnd_bvalid_hold", {63'd0, bus.bvalid}, 64'd1);
          check_val("rnd_bresp_hold", {62'd0, bus.bresp}, {62'd0, prev_bresp});
        end
      end
      prev_rstall = reg_wvalid && !reg_wready;
      prev_bstall = bus.bvalid && !bus.bready;
      prev_wr     = {reg_windex, reg_wdata, reg_wstrb};
      prev_bresp  = bus.bresp;
    end
  end

  // Random readiness of the register file and the B consumer.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rnd_en) begin
        reg_wready = 1'($urandom_range(0, 1));
        bus.bready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic aw_thread(input int dly, input logic [7:0] addr);
    bit ok, hs;
    ok = 1'b0;
    repeat (dly) step();
    bus.awvalid = 1'b1; bus.awaddr = addr; bus.awprot = 3'($urandom_range(0, 7));
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      hs = bus.awready;
      step();
      if (hs) begin ok = 1'b1; break; end
    end
    bus.awvalid = 1'b0;
    if (!ok) check_val("aw_timeout", 64'd0, 64'd1);
  endtask

  task automatic w_thread(input int dly, input logic [31:0] data, input logic [3:0] strb);
    bit ok, hs;
    ok = 1'b0;
    repeat (dly) step();
    bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb;
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      hs = bus.wready;
      step();
      if (hs) begin ok = 1'b1; break; end
    end
    bus.wvalid = 1'b0;
    if (!ok) check_val("w_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int   wr_base, b_base;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb  = '0;
    bus.bready  = 1'b0;

    // Reset values
    repeat (3) step();
    @(negedge clock);
    check_val("rst_awready", {63'd0, bus.awready}, 64'd0);
    check_val("rst_wready",  {63'd0, bus.wready},  64'd0);
    check_val("rst_bvalid",  {63'd0, bus.bvalid},  64'd0);
    check_val("rst_bresp",   {62'd0, bus.bresp},   64'd0);
    check_val("rst_reg_wvalid", {63'd0, reg_wvalid}, 64'd0);
    check_val("rst_payload", {22'd0, reg_windex, reg_wdata, reg_wstrb}, 64'd0);
    step();
    reset = 1'b0;
    @(negedge clock);
    check_val("rel_readies", {62'd0, bus.awready, bus.wready}, 64'd3);

    // Same-cycle AW+W
    step();
    reg_wready = 1'b1; bus.bready = 1'b1;
    drive_pair(8'h08, 32'hDEADBEEF, 4'hF);
    step();
    idle_bus();
    @(negedge clock);
    check_val("sc_reg_wvalid", {63'd0, reg_wvalid}, 64'd1);
    check_val("sc_payload", {22'd0, reg_windex, reg_wdata, reg_wstrb}, {22'd0, 6'd2, 32'hDEADBEEF, 4'hF});
    check_val("sc_busy_readies", {62'd0, bus.awready, bus.wready}, 64'd0);
    check_val("sc_bvalid_early", {63'd0, bus.bvalid}, 64'd0);
    step();
    @(negedge clock);
    check_val("sc_bvalid", {63'd0, bus.bvalid, reg_wvalid}, 64'd2);
    check_val("sc_bresp", {62'd0, bus.bresp}, 64'd0);
    step();
    @(negedge clock);
    check_val("sc_readies_back", {61'd0, bus.awready, bus.wready, bus.bvalid}, 64'd6);

    // W first, AW three cycles later
    bus.wvalid = 1'b1; bus.wdata = 32'h12345678; bus.wstrb = 4'h3;
    step();
    bus.wvalid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) begin bus.awvalid = 1'b1; bus.awaddr = 8'h3C; end
      @(negedge clock);
      check_val("wf_readies", {62'd0, bus.awready, bus.wready}, 64'd2);
      step();
    end
    bus.awvalid = 1'b0;
    @(negedge clock);
    check_val("wf_payload", {21'd0, reg_wvalid, reg_windex, reg_wdata, reg_wstrb},
              {21'd0, 1'b1, 6'd15, 32'h12345678, 4'h3});
    step();
    @(negedge clock);
    check_val("wf_resp", {61'd0, bus.bvalid, bus.bresp}, 64'd4);
    step();

    // Out-of-range index: error response, no register write
    wr_base = wr_q.size();
    drive_pair(8'h40, 32'hCAFEF00D, 4'hF);
    step();
    idle_bus();
    @(negedge clock);
    check_val("de_reg_wvalid", {63'd0, reg_wvalid}, 64'd0);
    check_val("de_resp", {61'd0, bus.bvalid, bus.bresp}, 64'd6);
    step();
    @(negedge clock);
    check_val("de_no_write", wr_q.size(), wr_base);

    // Backpressure, with competing AW/W held valid while busy
    step();
    reg_wready = 1'b0; bus.bready = 1'b0;
    wr_base = wr_q.size();
    drive_pair(8'h10, 32'hA5A55A5A, 4'h5);
    step();
    bus.awaddr = 8'h20; bus.wdata = 32'h0; bus.wstrb = 4'hA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_val("bp_wr_hold", {18'd0, reg_wvalid, bus.bvalid, bus.awready, bus.wready, reg_windex, reg_wdata, reg_wstrb},
                {18'd0, 4'b1000, 6'd4, 32'hA5A55A5A, 4'h5});
      step();
    end
    reg_wready = 1'b1;
    step();
    reg_wready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_val("bp_b_hold", {57'd0, reg_wvalid, bus.bvalid, bus.awready, bus.wready, bus.bresp}, 64'h10);
      step();
    end
    idle_bus();
    bus.bready = 1'b1;
    @(negedge clock);
    check_val("bp_bvalid_last", {63'd0, bus.bvalid}, 64'd1);
    step();
    @(negedge clock);
    check_val("bp_one_write", wr_q.size(), wr_base + 1);
    check_val("bp_sb_entry", {22'd0, wr_q[wr_q.size()-1]}, {22'd0, 6'd4, 32'hA5A55A5A, 4'h5});

    // Reset while a write request is pending
    step();
    reg_wready = 1'b0;
    wr_base = wr_q.size();
    b_base  = b_cnt;
    drive_pair(8'h18, 32'h55AA55AA, 4'hC);
    step();
    idle_bus();
    @(negedge clock);
    check_val("rm_pending", {63'd0, reg_wvalid}, 64'd1);
    reset = 1'b1;
    reg_wready = 1'b1;
    #1;
    check_val("rm_in_reset", {60'd0, reg_wvalid, bus.bvalid, bus.awready, bus.wready}, 64'd0);
    step();
    reset = 1'b0;
    @(negedge clock);
    check_val("rm_after", {60'd0, reg_wvalid, bus.bvalid, bus.awready, bus.wready}, 64'd3);
    check_val("rm_index_cleared", {58'd0, reg_windex}, 64'd0);
    check_val("rm_dropped", {32'(wr_q.size() - wr_base), 32'(b_cnt - b_base)}, 64'd0);
    step();
    drive_pair(8'h04, 32'h0BADF00D, 4'hF);
    step();
    idle_bus();
    @(negedge clock);
    check_val("rm_fresh_wr", {21'd0, reg_wvalid, reg_windex, reg_wdata, reg_wstrb},
              {21'd0, 1'b1, 6'd1, 32'h0BADF00D, 4'hF});
    step();
    @(negedge clock);
    check_val("rm_fresh_resp", {61'd0, bus.bvalid, bus.bresp}, 64'd4);
    step();

    // Zero strobes still produce a write and OKAY
    drive_pair(8'h2C, 32'h01020304, 4'h0);
    step();
    idle_bus();
    @(negedge clock);
    check_val("zs_write", {21'd0, reg_wvalid, reg_windex, reg_wdata, reg_wstrb},
              {21'd0, 1'b1, 6'd11, 32'h01020304, 4'h0});
    step();
    @(negedge clock);
    check_val("zs_resp", {61'd0, bus.bvalid, bus.bresp}, 64'd4);
    step();

    // Randomised back-to-back transactions
    wr_q.delete();
    exp_q.delete();
    b_base = b_cnt;
    slverr_cnt = 0;
    mon_en = 1'b1;
    rnd_en = 1'b1;
    for (int t = 0; t < 10; t++) begin
      bit done;
      s = 4'($urandom_range(0, 15));
      a = {s, 2'($urandom_range(0, 3))};
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      exp_q.push_back({2'b00, a[7:2], d, s});
      fork
        aw_thread(int'($urandom_range(0, 3)), a);
        w_thread(int'($urandom_range(0, 3)), d, s);
      join
      done = 1'b0;
      for (int k = 0; k < 100; k++) begin
        if (b_cnt == b_base + t + 1) begin done = 1'b1; break; end
        step();
      end
      if (!done) check_val("b_timeout", 64'd0, 64'd1);
    end
    rnd_en = 1'b0;
    mon_en = 1'b0;
    check_val("rnd_wr_count", wr_q.size(), 64'd10);
    check_val("rnd_b_count", b_cnt - b_base, 64'd10);
    check_val("rnd_no_slverr", slverr_cnt, 64'd0);
    for (int i = 0; i < 10; i++)
      if (i < wr_q.size()) check_val($sformatf("rnd_sb_%0d", i), {22'd0, wr_q[i]}, {22'd0, exp_q[i]});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_lite_write_slave.md
Name: axi_lite_write_slave

Overview:
- Consumes an AXI4-Lite write address channel (AW) and write data channel (W); produces the write response channel (B).
- Converts each accepted AW+W pair into a single-beat register write request towards a local register file.
- Sits directly downstream of the write address channel interface, on the slave side of the SP control port.
- Handles one outstanding transaction; AW and W may arrive in either order or in the same cycle.

Parameters:
AXI_AWADDR_WIDTH, 8, byte address width of AW channel
AXI_DATA_WIDTH, 32, W data width; must be 32 (word-addressed register file)
REG_COUNT, 16, number of 32-bit registers; word index = awaddr[AXI_AWADDR_WIDTH-1:2]

Ports:
clock  in  1  single clock, all logic rising-edge
reset  in  1  synchronous, active-high
awvalid  in  1  AW valid
awready  out  1  AW ready
awaddr  in  AXI_AWADDR_WIDTH  byte address
awprot  in  3  protection; captured, not used for decode
wvalid  in  1  W valid
wready  out  1  W ready
wdata  in  AXI_DATA_WIDTH  write data
wstrb  in  AXI_DATA_WIDTH/8  byte strobes
bvalid  out  1  B valid
bready  in  1  B ready
bresp  out  2  00 OKAY, 10 SLVERR
reg_wvalid  out  1  register write request
reg_wready  in  1  register file accepts request
reg_windex  out  AXI_AWADDR_WIDTH-2  word index
reg_wdata  out  AXI_DATA_WIDTH  data
reg_wstrb  out  AXI_DATA_WIDTH/8  byte strobes

Behaviour:
- Reset: state=IDLE; awready=0, wready=0, bvalid=0, bresp=00, reg_wvalid=0 while reset high. reg_windex/reg_wdata/reg_wstrb reset to 0.
- awready = (state==IDLE || state==HAVE_W) && !reset; wready = (state==IDLE || state==HAVE_AW) && !reset (combinational from registered state). Both are 1 in the first cycle after reset release.
- AW handshake (awvalid&&awready) captures awaddr[AXI_AWADDR_WIDTH-1:2] into windex and awprot. awaddr[1:0] are ignored.
- W handshake captures wdata and wstrb.
- States:
  - IDLE: both handshakes in the same cycle -> DECIDE. AW only -> HAVE_AW. W only -> HAVE_W.
  - HAVE_AW: W handshake -> DECIDE.
  - HAVE_W: AW handshake -> DECIDE.
  - DECIDE is folded into the transition edge:
    - index < REG_COUNT -> WRITE.
    - otherwise -> RESP with bresp=10; no register write is issued.
  - WRITE: reg_wvalid=1 with stable index/data/strb until reg_wready. On handshake -> RESP with bresp=00.
  - RESP: bvalid=1, bresp stable until bready -> IDLE.
- Latency: AW and W handshaked at edge N -> reg_wvalid high after N. If reg_wready=1 immediately, bvalid high after N+1. bvalid&&bready at edge M -> awready/wready high after M.
- wstrb=0 is still a valid write: reg_wvalid is issued with reg_wstrb=0 and the response is OKAY.
- No new AW/W is accepted from WRITE or RESP. A second AW arriving in HAVE_AW is stalled (awready=0).
- Valids never depend on readies: reg_wvalid and bvalid are asserted regardless of reg_wready/bready.
- Reset mid-transaction: the pending transaction is dropped, no response is produced, outputs follow reset values, and the next cycle is IDLE.
- REG_COUNT must be less than or equal to 2^(AXI_AWADDR_WIDTH-2); the index compare is unsigned, full width.

Decomposition:
- Shared package axi_lite_pkg:
  - typedef axi_resp_t (2 bits).
  - Constants AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10.
  - State enum axi_lite_wr_state_t {IDLE, HAVE_AW, HAVE_W, WRITE, RESP}.
- Single module, no sub-module. Capture registers and FSM are small enough to stay flat.

Test Plan:
- Same-cycle: awaddr=0x08, wdata=0xDEADBEEF, wstrb=0xF, reg_wready=1, bready=1 -> reg_wvalid one cycle with windex=2, data 0xDEADBEEF; bvalid next cycle with bresp=00; readies high the cycle after.
- W before AW: W at cycle 0, AW (0x3C) at cycle 3 -> awready stays 1 and wready=0 during cycles 1-3; write at index 15, OKAY.
- Decode error: awaddr=0x40 with REG_COUNT=16 -> reg_wvalid never asserted; bvalid with bresp=10.
- Backpressure: reg_wready low 5 cycles, then bready low 4 cycles -> reg_wvalid and bvalid held stable with unchanged payload; awready/wready=0 throughout.
- Reset mid-op: reset asserted in WRITE state -> reg_wvalid=0 and bvalid=0 in the reset cycle; after release, a fresh transaction to 0x04 completes with OKAY.
- Back-to-back: 10 random transactions with random valid/ready gaps -> scoreboard matches index/data/strb order and response count; no handshake while the FSM is busy.
